// File: rtl/shift_transmitter_pkg.sv
// Shared definitions for the serial-link transmitter: FSM state encoding and default word width.
package shift_transmitter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/shift_transmitter_piso_core.sv
// Parallel-in/serial-out shift register with load and shift enables; exposes the bit that will
// sit on the serial tap after the current edge so the caller can register it in step.
module piso_core #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             so_next_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = data_i;
        end else if (shift_i) begin
            data_d = MSB_FIRST ? {data_q[WIDTH-2:0], 1'b0} : {1'b0, data_q[WIDTH-1:1]};
        end
    end

    assign so_next_o = MSB_FIRST ? data_d[WIDTH-1] : data_d[0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/shift_transmitter.sv
// Sending end of the serial link: one-word holding buffer behind a valid/ready handshake,
// framing FSM with per-bit strobe, optional idle gap between frames.
module shift_transmitter
    import shift_transmitter_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int BIT_CYCLES = 1,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d,
    output logic             d_ready,
    output logic             so,
    output logic             so_en,
    output logic             frame,
    output logic             done
);

    localparam int BIT_W = $clog2(WIDTH) + 1;
    localparam int CYC_W = $clog2(BIT_CYCLES) + 1;
    localparam int GAP_W = $clog2(GAP_CYCLES) + 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             so_q, so_d;
    logic             so_en_q, so_en_d;
    logic             frame_q, frame_d;
    logic             done_q, done_d;

    logic last_cyc, last_bit, frame_end, start, shift_en, so_next;

    assign last_cyc  = (cyc_q == CYC_LAST);
    assign last_bit  = (bit_q == BIT_LAST);
    assign frame_end = (state_q == ST_SHIFT) && last_cyc && last_bit;
    assign shift_en  = (state_q == ST_SHIFT) && last_cyc && !last_bit;

    // A new frame starts straight from IDLE, from the end of a gap, or back-to-back when no gap is configured.
    assign start = hold_full_q &&
                   ((state_q == ST_IDLE) ||
                    ((state_q == ST_GAP) && (gap_q == GAP_LAST)) ||
                    (frame_end && (GAP_CYCLES == 0)));

    piso_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .clk_i     (clk),
        .rst_i     (reset),
        .load_i    (start),
        .shift_i   (shift_en),
        .data_i    (hold_q),
        .so_next_o (so_next)
    );

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bit_d       = bit_q;
        cyc_d       = cyc_q;
        gap_d       = gap_q;
        so_d        = so_q;
        so_en_d     = 1'b0;
        frame_d     = frame_q;
        done_d      = 1'b0;

        case (state_q)
            ST_SHIFT: begin
                if (!last_cyc) begin
                    cyc_d = cyc_q + CYC_W'(1);
                end else if (!last_bit) begin
                    cyc_d   = '0;
                    bit_d   = bit_q + BIT_W'(1);
                    so_d    = so_next;
                    so_en_d = 1'b1;
                end else begin
                    cyc_d   = '0;
                    bit_d   = '0;
                    done_d  = 1'b1;
                    frame_d = 1'b0;
                    so_d    = 1'b0;
                    gap_d   = '0;
                    state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            ST_IDLE: ;
            default: state_d = ST_IDLE;
        endcase

        if (start) begin
            state_d     = ST_SHIFT;
            hold_full_d = 1'b0;
            bit_d       = '0;
            cyc_d       = '0;
            so_d        = so_next;
            so_en_d     = 1'b1;
            frame_d     = 1'b1;
        end

        // Accept only into an empty buffer; the flag stays set through the draining cycle.
        if (d_valid && !hold_full_q) begin
            hold_d      = d;
            hold_full_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bit_q       <= '0;
            cyc_q       <= '0;
            gap_q       <= '0;
            so_q        <= 1'b0;
            so_en_q     <= 1'b0;
            frame_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bit_q       <= bit_d;
            cyc_q       <= cyc_d;
            gap_q       <= gap_d;
            so_q        <= so_d;
            so_en_q     <= so_en_d;
            frame_q     <= frame_d;
            done_q      <= done_d;
        end
    end

    assign d_ready = ~hold_full_q;
    assign so      = so_q;
    assign so_en   = so_en_q;
    assign frame   = frame_q;
    assign done    = done_q;

endmodule

// File: tb/tb_shift_transmitter.sv
// Bench for shift_transmitter: three configurations checked every cycle against a frame-timeline
// model, plus hand-computed waveform expectations and a loopback receiver on the default instance.
module tb_shift_transmitter;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] dv;
    logic [3:0] dd [3];
    logic [2:0] rdy, so_w, en_w, fr_w, dn_w;

    int n_cmp  = 0;
    int n_fail = 0;
    bit armed  = 1'b0;

    always #5 clk = ~clk;

    shift_transmitter #(.WIDTH(4), .MSB_FIRST(1'b1), .BIT_CYCLES(1), .GAP_CYCLES(0)) u0 (
        .clk(clk), .reset(reset), .d_valid(dv[0]), .d(dd[0]), .d_ready(rdy[0]),
        .so(so_w[0]), .so_en(en_w[0]), .frame(fr_w[0]), .done(dn_w[0]));

    shift_transmitter #(.WIDTH(4), .MSB_FIRST(1'b0), .BIT_CYCLES(3), .GAP_CYCLES(0)) u1 (
        .clk(clk), .reset(reset), .d_valid(dv[1]), .d(dd[1]), .d_ready(rdy[1]),
        .so(so_w[1]), .so_en(en_w[1]), .frame(fr_w[1]), .done(dn_w[1]));

    shift_transmitter #(.WIDTH(4), .MSB_FIRST(1'b1), .BIT_CYCLES(1), .GAP_CYCLES(2)) u2 (
        .clk(clk), .reset(reset), .d_valid(dv[2]), .d(dd[2]), .d_ready(rdy[2]),
        .so(so_w[2]), .so_en(en_w[2]), .frame(fr_w[2]), .done(dn_w[2]));

    task automatic check(input string name, input int k, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[u%0d] got %0h expected %0h at %0t", name, k, got, exp, $time);
        end
    endtask

    // Model: a frame is a time index t over WIDTH*BIT_CYCLES clocks; bit = t / BIT_CYCLES.
    typedef struct {
        bit       hold_full;
        bit [3:0] hold;
        bit       active;
        bit [3:0] word;
        int       t;
        int       gap;
        bit       done;
    } mstate_t;

    mstate_t m [3];

    function automatic bit msb_of(input int k); return (k != 1); endfunction
    function automatic int bc_of(input int k);  return (k == 1) ? 3 : 1; endfunction
    function automatic int gap_of(input int k); return (k == 2) ? 2 : 0; endfunction

    function automatic mstate_t step(input mstate_t s, input int k, input bit v, input bit [3:0] din);
        mstate_t n;
        bit take, start;
        n     = s;
        take  = v && !s.hold_full;
        start = 1'b0;
        n.done = 1'b0;
        if (s.active) begin
            if (s.t == 4 * bc_of(k) - 1) begin
                n.done   = 1'b1;
                n.active = 1'b0;
                if (gap_of(k) == 0) start = s.hold_full;
                else                n.gap = gap_of(k);
            end else begin
                n.t = s.t + 1;
            end
        end else if (s.gap > 0) begin
            n.gap = s.gap - 1;
            if (n.gap == 0) start = s.hold_full;
        end else begin
            start = s.hold_full;
        end
        if (start) begin
            n.active    = 1'b1;
            n.word      = s.hold;
            n.t         = 0;
            n.hold_full = 1'b0;
        end
        if (take) begin
            n.hold_full = 1'b1;
            n.hold      = din;
        end
        return n;
    endfunction

    function automatic bit m_so(input int k);
        int idx;
        if (!m[k].active) return 1'b0;
        idx = m[k].t / bc_of(k);
        return msb_of(k) ? m[k].word[3-idx] : m[k].word[idx];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) m[k] = '{default: 0};
            armed = 1'b1;
        end else begin
            for (int k = 0; k < 3; k++) m[k] = step(m[k], k, dv[k], dd[k]);
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 3; k++) begin
                check("model_so",     k, 16'(so_w[k]), 16'(m_so(k)));
                check("model_so_en",  k, 16'(en_w[k]), 16'(m[k].active && (m[k].t % bc_of(k) == 0)));
                check("model_frame",  k, 16'(fr_w[k]), 16'(m[k].active));
                check("model_done",   k, 16'(dn_w[k]), 16'(m[k].done));
                check("model_dready", k, 16'(rdy[k]),  16'(!m[k].hold_full));
            end
        end
    end

    // Loopback receiver: shifts so in on each strobe, first bit ends up in the MSB.
    logic [3:0] rx;
    always @(posedge clk or posedge reset) begin
        if (reset)        rx <= 4'b0;
        else if (en_w[0]) rx <= {rx[2:0], so_w[0]};
    end

    task automatic send(input int k, input int n, input logic [7:0] words);
        for (int i = 0; i < n; i++) begin
            int g;
            @(negedge clk);
            dv[k] = 1'b1;
            dd[k] = (i == 0) ? words[7:4] : words[3:0];
            g = 0;
            while (!rdy[k] && g < 50) begin
                @(negedge clk);
                g++;
            end
            if (!rdy[k]) check("send_timeout", k, 16'd0, 16'd1);
            @(posedge clk);
        end
        @(negedge clk);
        dv[k] = 1'b0;
    endtask

    task automatic wait_frame(input int k);
        int g;
        g = 0;
        @(negedge clk);
        while (!fr_w[k] && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!fr_w[k]) check("frame_timeout", k, 16'd0, 16'd1);
    endtask

    // Records n cycles starting at the first cycle with frame high; cycle 0 ends up in the highest bit.
    task automatic capture(input int k, input int n,
                           output logic [15:0] so_v, output logic [15:0] en_v, output logic [15:0] fr_v,
                           output logic [15:0] dn_v, output logic [15:0] rd_v);
        so_v = '0; en_v = '0; fr_v = '0; dn_v = '0; rd_v = '0;
        wait_frame(k);
        for (int i = 0; i < n; i++) begin
            so_v = {so_v[14:0], so_w[k]};
            en_v = {en_v[14:0], en_w[k]};
            fr_v = {fr_v[14:0], fr_w[k]};
            dn_v = {dn_v[14:0], dn_w[k]};
            rd_v = {rd_v[14:0], rdy[k]};
            if (i < n - 1) @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog[u0] got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        logic [15:0] so_v, en_v, fr_v, dn_v, rd_v;
        dv = 3'b000;
        for (int k = 0; k < 3; k++) dd[k] = 4'h0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_dready", k, 16'(rdy[k]),  16'd1);
            check("rst_frame",  k, 16'(fr_w[k]), 16'd0);
            check("rst_so",     k, 16'(so_w[k]), 16'd0);
        end

        // Reset in the middle of a frame of 1011, after two bits.
        fork
            send(0, 1, {4'b1011, 4'b0000});
            wait_frame(0);
        join
        @(negedge clk);
        @(posedge clk);
        #2;
        check("mid_frame_before_rst", 0, 16'(fr_w[0]), 16'd1);
        reset = 1'b1;
        #1;
        check("async_rst_so",     0, 16'(so_w[0]), 16'd0);
        check("async_rst_so_en",  0, 16'(en_w[0]), 16'd0);
        check("async_rst_frame",  0, 16'(fr_w[0]), 16'd0);
        check("async_rst_done",   0, 16'(dn_w[0]), 16'd0);
        check("async_rst_dready", 0, 16'(rdy[0]),  16'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_rst_done",   0, 16'(dn_w[0]), 16'd0);
            check("post_rst_so",     0, 16'(so_w[0]), 16'd0);
            check("post_rst_dready", 0, 16'(rdy[0]),  16'd1);
        end

        // 1001 MSB first, one clock per bit, plus loopback.
        fork
            send(0, 1, {4'b1001, 4'b0000});
            capture(0, 5, so_v, en_v, fr_v, dn_v, rd_v);
        join
        check("t2_so",    0, so_v, 16'b10010);
        check("t2_so_en", 0, en_v, 16'b11110);
        check("t2_frame", 0, fr_v, 16'b11110);
        check("t2_done",  0, dn_v, 16'b00001);
        check("loopback_q", 0, 16'(rx), 16'b1001);
        repeat (3) @(negedge clk);

        // 1100 LSB first, three clocks per bit.
        fork
            send(1, 1, {4'b1100, 4'b0000});
            capture(1, 13, so_v, en_v, fr_v, dn_v, rd_v);
        join
        check("t3_so",    1, so_v, 16'b0000001111110);
        check("t3_so_en", 1, en_v, 16'b1001001001000);
        check("t3_frame", 1, fr_v, 16'b1111111111110);
        check("t3_done",  1, dn_v, 16'b0000000000001);
        repeat (3) @(negedge clk);

        // Back-to-back 1001 then 0110, no gap.
        fork
            send(0, 2, {4'b1001, 4'b0110});
            capture(0, 9, so_v, en_v, fr_v, dn_v, rd_v);
        join
        check("t4_so",     0, so_v, 16'b100101100);
        check("t4_frame",  0, fr_v, 16'b111111110);
        check("t4_done",   0, dn_v, 16'b000010001);
        check("t4_dready", 0, rd_v, 16'b100011111);
        repeat (3) @(negedge clk);

        // Two words with a two-clock gap.
        fork
            send(2, 2, {4'b1001, 4'b0110});
            capture(2, 11, so_v, en_v, fr_v, dn_v, rd_v);
        join
        check("t5_so",    2, so_v, 16'b10010001100);
        check("t5_frame", 2, fr_v, 16'b11110011110);
        check("t5_done",  2, dn_v, 16'b00001000001);
        check("t5_so_en", 2, en_v, 16'b11110011110);
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
